// File: rtl/fsm_run_generator_pkg.sv
// fsm_run_generator_pkg: shared states and constants for the run generator and its run tracker.
package fsm_run_generator_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
   localparam int LEN_W_DEF = 4;
   localparam logic [2:0] RUN_SAT = 3'd4;
endpackage

// File: rtl/fsm_run_generator_if.sv
// fsm_run_generator_if: run command handshake plus the serial stream and its golden detector output.
interface fsm_run_generator_if import fsm_run_generator_pkg::*; #(parameter int LEN_W = LEN_W_DEF) ();
   logic             cmd_valid;
   logic             cmd_bit;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_ready;
   logic             w;
   logic             w_valid;
   logic             z_exp;
   logic [1:0]       y;
   modport master (output cmd_valid, cmd_bit, cmd_len, input cmd_ready, w, w_valid, z_exp, y);
   modport slave (input cmd_valid, cmd_bit, cmd_len, output cmd_ready, w, w_valid, z_exp, y);
endinterface

// File: rtl/fsm_run_tracker.sv
// fsm_run_tracker: counts consecutive equal valid bits (saturating) and flags a run of four.
module fsm_run_tracker import fsm_run_generator_pkg::*; (
   input  logic clk,
   input  logic reset,
   input  logic v,
   input  logic b,
   output logic z
);
   logic [2:0] cnt;
   logic       prev;
   logic       first;
   // Only valid bits advance the count, so idle gaps never break a run.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         prev  <= 1'b0;
         first <= 1'b1;
      end else if (v) begin
         cnt   <= (first || b != prev) ? 3'd1 : (cnt == RUN_SAT ? RUN_SAT : cnt + 3'd1);
         prev  <= b;
         first <= 1'b0;
      end
   end
   assign z = cnt == RUN_SAT;
endmodule

// File: rtl/fsm_run_generator.sv
// fsm_run_generator: expands (bit, length) run commands into a serial stream with a golden detector output.
module fsm_run_generator import fsm_run_generator_pkg::*; #(parameter int LEN_W = LEN_W_DEF) (
   input logic                clk,
   input logic                reset,
   fsm_run_generator_if.slave bus
);
   state_t           state, state_n;
   logic [LEN_W-1:0] rem, rem_n;
   logic             bit_q, bit_n;
   logic             sending, last, ready, accept;
   assign sending = state == SEND;
   assign last    = sending && rem == LEN_W'(1);
   assign ready   = !sending || last;
   assign accept  = bus.cmd_valid && ready;
   // A nonzero command accepted on the final bit reloads in place, keeping the stream gap-free.
   always_comb begin
      state_n = state;
      rem_n   = rem;
      bit_n   = bit_q;
      if (sending) begin
         rem_n   = rem - LEN_W'(1);
         state_n = last ? IDLE : SEND;
      end
      if (accept && bus.cmd_len != '0) begin
         state_n = SEND;
         rem_n   = bus.cmd_len;
         bit_n   = bus.cmd_bit;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         rem   <= '0;
         bit_q <= 1'b0;
      end else begin
         state <= state_n;
         rem   <= rem_n;
         bit_q <= bit_n;
      end
   end
   assign bus.cmd_ready = ready;
   assign bus.w         = bit_q;
   assign bus.w_valid   = sending;
   assign bus.y         = state;
   fsm_run_tracker u_tracker (
      .clk   (clk),
      .reset (reset),
      .v     (sending),
      .b     (bit_q),
      .z     (bus.z_exp)
   );
endmodule

// File: tb/tb_fsm_run_generator.sv
// tb_fsm_run_generator: scenario tasks checked against a queue-based stream model and a reference detector.
module tb_fsm_run_generator;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   fsm_run_generator_if #(.LEN_W(4)) bus ();
   fsm_run_generator #(.LEN_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   int errors = 0;
   int checks = 0;
   int acc = 0;
   bit q[$];
   bit hist[$];
   bit last_bit;
   logic [5:0] exp_o;
   logic [5:0] obs;
   assign obs = {bus.cmd_ready, bus.w_valid, bus.w, bus.z_exp, bus.y};

   // Independent detector, clock-enabled by w_valid: last four valid bits equal.
   logic [3:0] det_sh;
   logic [2:0] det_n;
   logic       det_z;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         det_sh <= '0;
         det_n  <= '0;
      end else if (bus.w_valid) begin
         det_sh <= {det_sh[2:0], bus.w};
         det_n  <= det_n == 3'd4 ? 3'd4 : det_n + 3'd1;
      end
   end
   assign det_z = det_n == 3'd4 && (det_sh == 4'hF || det_sh == 4'h0);

   task automatic model_reset();
      q.delete();
      hist.delete();
      last_bit = 1'b0;
   endtask

   task automatic model_comb();
      logic v, wb, z;
      v = q.size() > 0;
      wb = v ? q[0] : last_bit;
      z = hist.size() == 4 && hist[0] == hist[1] && hist[1] == hist[2] && hist[2] == hist[3];
      exp_o = {q.size() <= 1, v, wb, z, 1'b0, v};
   endtask

   task automatic model_edge();
      bit take;
      take = bus.cmd_valid && q.size() <= 1;
      if (q.size() > 0) begin
         hist.push_back(q[0]);
         if (hist.size() > 4) void'(hist.pop_front());
         last_bit = q.pop_front();
      end
      if (take) begin
         acc++;
         repeat (int'(bus.cmd_len)) q.push_back(bus.cmd_bit);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_comb();
   endtask

   task automatic drive(input logic v, input logic b, input logic [3:0] l);
      bus.cmd_valid = v;
      bus.cmd_bit = b;
      bus.cmd_len = l;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b0, 1'b0, 4'd0);
      #3;
      checks++;
      if (obs !== 6'b100000) begin errors++; $display("FAIL reset got %b want %b", obs, 6'b100000); end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      model_comb();
   endtask

   task automatic test_single();
      int nv = 0;
      logic zs = 1'b0;
      drive(1'b1, 1'b1, 4'd4);
      cycle();
      drive(1'b0, 1'b0, 4'd7);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (obs !== exp_o) begin errors++; $display("FAIL single c%0d got %b want %b", i, obs, exp_o); end
         nv += int'(bus.w_valid);
         zs |= bus.z_exp;
         if (i == 5) drive(1'b0, 1'b1, 4'd3);
         cycle();
      end
      checks++;
      if (nv != 4) begin errors++; $display("FAIL single_count got %0d want 4", nv); end
      checks++;
      if ({zs, bus.y} !== 3'b100) begin errors++; $display("FAIL single_end got z=%b y=%0d want z=1 y=0", zs, bus.y); end
   endtask

   task automatic test_back_to_back();
      int a0 = acc;
      int nv = 0;
      logic [7:0] bits = '0;
      drive(1'b1, 1'b0, 4'd3);
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (obs !== exp_o) begin errors++; $display("FAIL b2b c%0d got %b want %b", i, obs, exp_o); end
         if (bus.w_valid) begin bits = {bits[6:0], bus.w}; nv++; end
         if (acc == a0 + 1) drive(1'b1, 1'b1, 4'd5);
         if (acc >= a0 + 2) drive(1'b0, 1'b0, 4'd0);
         cycle();
      end
      checks++;
      if (nv != 8 || bits !== 8'b00011111) begin errors++; $display("FAIL b2b_stream got %0d bits %b want 8 bits 00011111", nv, bits); end
   endtask

   task automatic test_gap();
      logic [5:0] tbl [14] = '{6'h21, 6'h00, 6'h32, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h32, 6'h00, 6'h00, 6'h00, 6'h00};
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (obs !== exp_o) begin errors++; $display("FAIL gap c%0d got %b want %b", i, obs, exp_o); end
         if (i == 9) begin
            checks++;
            if (bus.z_exp !== 1'b0) begin errors++; $display("FAIL gap_mid got z=%b want 0", bus.z_exp); end
         end
         drive(tbl[i][5], tbl[i][4], tbl[i][3:0]);
         cycle();
      end
      checks++;
      if (bus.z_exp !== 1'b1) begin errors++; $display("FAIL gap_end got z=%b want 1", bus.z_exp); end
   endtask

   task automatic test_zero_len();
      drive(1'b1, 1'b0, 4'd0);
      cycle();
      checks++;
      if ({bus.w_valid, bus.y} !== 3'b000) begin errors++; $display("FAIL zero_idle got v=%b y=%0d want v=0 y=0", bus.w_valid, bus.y); end
      drive(1'b1, 1'b0, 4'd2);
      cycle();
      drive(1'b0, 1'b1, 4'd9);
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL zero_run got %b want %b", obs, exp_o); end
      cycle();
      drive(1'b1, 1'b1, 4'd0);
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL zero_final got %b want %b", obs, exp_o); end
      cycle();
      drive(1'b0, 1'b0, 4'd0);
      checks++;
      if ({bus.w_valid, bus.y, bus.cmd_ready} !== 4'b0001) begin errors++; $display("FAIL zero_after got v=%b y=%0d r=%b want v=0 y=0 r=1", bus.w_valid, bus.y, bus.cmd_ready); end
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL zero_model got %b want %b", obs, exp_o); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b1, 4'd15);
      cycle();
      drive(1'b0, 1'b0, 4'd0);
      cycle();
      cycle();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL rmid_bit3 got %b want %b", obs, exp_o); end
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== 6'b100000) begin errors++; $display("FAIL rmid_abort got %b want %b", obs, 6'b100000); end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_comb();
      drive(1'b1, 1'b0, 4'd4);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (obs !== exp_o) begin errors++; $display("FAIL rmid_after c%0d got %b want %b", i, obs, exp_o); end
         cycle();
         drive(1'b0, 1'b1, 4'd8);
      end
      checks++;
      if ({bus.z_exp, bus.w, bus.y} !== 4'b1000) begin errors++; $display("FAIL rmid_end got z=%b w=%b y=%0d want z=1 w=0 y=0", bus.z_exp, bus.w, bus.y); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         checks++;
         if (obs !== exp_o) begin errors++; $display("FAIL rand c%0d got %b want %b", i, obs, exp_o); end
         checks++;
         if (bus.z_exp !== det_z) begin errors++; $display("FAIL rand_det c%0d got z_exp=%b want %b", i, bus.z_exp, det_z); end
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 4) == 0 ? 4'd0 : 4'($urandom_range(1, 6)));
         cycle();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gap();
      test_zero_len();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
